// File: rtl/pc_sequencer.sv
// Instruction sequencer: owns the PC, runs the imem fetch handshake, holds each
// instruction through execution and picks PC+4 or the branch target on retire.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] pc,
    input  logic        exec_done,
    input  logic        next_pc_src,
    input  logic [31:0] target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        halted,
    output logic        trap,
    output logic [31:0] trap_pc,
    output logic [31:0] trap_tval,
    output logic [31:0] instret,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2,
        S_TRAP  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc_seq_s;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    assign pc_seq_s   = pc + 32'd4;
    assign fetch_addr = pc;

    // Sequencer state, PC, retire counters and trap capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            pc        <= RESET_PC;
            instr     <= 32'd0;
            trap_pc   <= 32'd0;
            trap_tval <= 32'd0;
            instret   <= 32'd0;
            taken_cnt <= 32'd0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (fetch_ack) begin
                        instr <= fetch_rdata;
                        state <= S_EXEC;
                    end else if (halt_req) begin
                        state <= S_HALT;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (next_pc_src && is_misaligned(target)) begin
                            // Faulting instruction does not retire; PC and counters stay put.
                            trap_pc   <= pc;
                            trap_tval <= target;
                            state     <= S_TRAP;
                        end else begin
                            if (next_pc_src) begin
                                pc        <= target;
                                taken_cnt <= taken_cnt + 32'd1;
                            end else begin
                                pc <= pc_seq_s;
                            end
                            instret <= instret + 32'd1;
                            state   <= halt_req ? S_HALT : S_FETCH;
                        end
                    end
                end
                S_HALT: begin
                    if (resume && !halt_req) begin
                        state <= S_FETCH;
                    end
                end
                S_TRAP: begin
                    state <= S_TRAP;
                end
                default: begin
                    state <= S_TRAP;
                end
            endcase
        end
    end

    // Moore decode of the state; request and valid are also kept quiet while reset is held.
    always_comb begin
        fetch_req   = 1'b0;
        instr_valid = 1'b0;
        if (rst_n) begin
            fetch_req   = (state == S_FETCH);
            instr_valid = (state == S_EXEC);
        end else begin
            fetch_req   = 1'b0;
            instr_valid = 1'b0;
        end
        halted = (state == S_HALT);
        trap   = (state == S_TRAP);
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected fetches and state
// snapshots, a negedge monitor pops and compares them as the DUT presents them.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic        exec_done;
    logic        next_pc_src;
    logic [31:0] target;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic [31:0] instret;
    logic [31:0] taken_cnt;

    pc_sequencer #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ack(fetch_ack), .fetch_rdata(fetch_rdata),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .exec_done(exec_done), .next_pc_src(next_pc_src), .target(target),
        .halt_req(halt_req), .resume(resume), .halted(halted), .trap(trap),
        .trap_pc(trap_pc), .trap_tval(trap_tval),
        .instret(instret), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] tk;
        logic [31:0] rdata;
        int          gap;
    } fexp_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] tk;
        logic [31:0] tpc;
        logic [31:0] tval;
        logic [3:0]  flags;  // {fetch_req, instr_valid, halted, trap}
    } sexp_t;

    fexp_t fq[$];
    sexp_t sq[$];
    int    snap_cnt = 0;
    int    snap_seen = 0;
    logic  done = 1'b0;

    int    checks = 0;
    int    failures = 0;

    // monitor-owned state
    int          cycle = 0;
    int          cur_start = 0;
    int          prev_start = 0;
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [31:0] prev_addr = 32'd0;
    logic        pend = 1'b0;
    logic [31:0] pend_rdata = 32'd0;
    fexp_t       fe;
    sexp_t       se;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_snap(input logic [31:0] p, input logic [31:0] i, input logic [31:0] t,
                             input logic [31:0] tp, input logic [31:0] tv, input logic [3:0] f);
        sq.push_back('{p, i, t, tp, tv, f});
        snap_cnt++;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One instruction: optional imem waits, optional exec waits with junk branch inputs.
    task automatic do_instr(input logic [31:0] addr, input logic [31:0] inst, input logic [31:0] tk,
                            input logic [31:0] rdata, input int gap, input int ack_wait,
                            input int done_wait, input logic take, input logic [31:0] tgt,
                            input logic hlt);
        fq.push_back('{addr, inst, tk, rdata, gap});
        fetch_rdata = 32'hDEAD_BEEF;
        repeat (ack_wait) tick();
        fetch_ack   = 1'b1;
        fetch_rdata = rdata;
        tick();
        fetch_rdata = 32'hDEAD_BEEF;
        if (done_wait > 0) begin
            fetch_ack   = 1'b1;
            next_pc_src = 1'b1;
            target      = 32'h0000_0003;
        end else begin
            fetch_ack = 1'b0;
        end
        repeat (done_wait) tick();
        fetch_ack   = 1'b0;
        exec_done   = 1'b1;
        next_pc_src = take;
        target      = tgt;
        halt_req    = hlt;
        tick();
        exec_done   = 1'b0;
        next_pc_src = 1'b0;
        target      = 32'd0;
        halt_req    = 1'b0;
    endtask

    // Stimulus
    initial begin
        rst_n = 1'b0; fetch_ack = 1'b0; fetch_rdata = 32'd0; exec_done = 1'b0;
        next_pc_src = 1'b0; target = 32'd0; halt_req = 1'b0; resume = 1'b0;
        tick(); tick();
        push_snap(32'h100, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000);
        tick();
        rst_n = 1'b1;
        // sequential run from reset, then taken branch at 0x108
        do_instr(32'h100, 32'd0, 32'd0, 32'h1111_0001, 0, 0, 0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h104, 32'd1, 32'd0, 32'h1111_0002, 2, 0, 0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h108, 32'd2, 32'd0, 32'h1111_0003, 2, 0, 0, 1'b1, 32'h40, 1'b0);
        // wait states: ack after 3, exec_done after 2 -> next fetch 7 cycles later
        do_instr(32'h40, 32'd3, 32'd1, 32'h2222_0004, 2, 3, 2, 1'b0, 32'd0, 1'b0);
        do_instr(32'h44, 32'd4, 32'd1, 32'h2222_0005, 7, 0, 0, 1'b1, 32'h200, 1'b0);
        // halt during FETCH with no ack
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        push_snap(32'h200, 32'd5, 32'd2, 32'd0, 32'd0, 4'b0010);
        tick();
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0;
        push_snap(32'h200, 32'd5, 32'd2, 32'd0, 32'd0, 4'b0010);
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        // refetch same PC; halt in the exec_done cycle retires then halts
        do_instr(32'h200, 32'd5, 32'd2, 32'h3333_0006, 0, 0, 0, 1'b0, 32'd0, 1'b1);
        push_snap(32'h204, 32'd6, 32'd2, 32'd0, 32'd0, 4'b0010);
        tick();
        resume = 1'b1;
        tick();
        resume = 1'b0;
        // PC wrap
        do_instr(32'h204, 32'd6, 32'd2, 32'h4444_0007, 0, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        do_instr(32'hFFFF_FFFC, 32'd7, 32'd3, 32'h4444_0008, 2, 0, 0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h0, 32'd8, 32'd3, 32'h4444_0009, 2, 0, 0, 1'b0, 32'd0, 1'b1);
        push_snap(32'h4, 32'd9, 32'd3, 32'd0, 32'd0, 4'b0010);
        tick();
        // preload instret while halted, then retire once to wrap it
        force dut.instret = 32'hFFFF_FFFF;
        #1;
        release dut.instret;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        do_instr(32'h4, 32'hFFFF_FFFF, 32'd3, 32'h5555_000A, 0, 0, 0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h8, 32'd0, 32'd3, 32'h5555_000B, 2, 0, 0, 1'b1, 32'h200, 1'b0);
        // misaligned taken target traps
        do_instr(32'h200, 32'd1, 32'd4, 32'h6666_000C, 2, 0, 0, 1'b1, 32'h42, 1'b0);
        fetch_ack = 1'b1; exec_done = 1'b1; resume = 1'b1; next_pc_src = 1'b1; target = 32'h80;
        push_snap(32'h200, 32'd1, 32'd4, 32'h200, 32'h42, 4'b0001);
        repeat (3) tick();
        push_snap(32'h200, 32'd1, 32'd4, 32'h200, 32'h42, 4'b0001);
        tick();
        fetch_ack = 1'b0; exec_done = 1'b0; resume = 1'b0; next_pc_src = 1'b0; target = 32'd0;
        // reset clears the trap
        rst_n = 1'b0;
        tick();
        push_snap(32'h100, 32'd0, 32'd0, 32'd0, 32'd0, 4'b0000);
        tick();
        rst_n = 1'b1;
        do_instr(32'h100, 32'd0, 32'd0, 32'h7777_000D, 0, 0, 0, 1'b0, 32'd0, 1'b0);
        do_instr(32'h104, 32'd1, 32'd0, 32'h7777_000E, 2, 0, 0, 1'b0, 32'd0, 1'b0);
        tick(); tick();
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (pend) begin
                chk("instr_valid", {31'd0, instr_valid}, 32'd1);
                chk("instr_latched", instr, pend_rdata);
                pend = 1'b0;
            end
            if (fetch_req && prev_req && !prev_ack) begin
                chk("fetch_addr_stable", fetch_addr, prev_addr);
            end
            if (fetch_req && !prev_req) begin
                prev_start = cur_start;
                cur_start  = cycle;
            end
            if (fetch_req && fetch_ack) begin
                if (fq.size() == 0) begin
                    chk("fetch_queue_depth", 32'(fq.size()), 32'd1);
                end else begin
                    fe = fq.pop_front();
                    chk("fetch_addr", fetch_addr, fe.addr);
                    chk("instret_at_fetch", instret, fe.inst);
                    chk("taken_cnt_at_fetch", taken_cnt, fe.tk);
                    if (fe.gap != 0) begin
                        chk("cycles_per_instr", 32'(cur_start - prev_start), 32'(fe.gap));
                    end
                    pend       = 1'b1;
                    pend_rdata = fe.rdata;
                end
            end
            if (snap_cnt != snap_seen && sq.size() != 0) begin
                se = sq.pop_front();
                snap_seen++;
                chk("snap_pc", pc, se.pc);
                chk("snap_instret", instret, se.inst);
                chk("snap_taken_cnt", taken_cnt, se.tk);
                chk("snap_trap_pc", trap_pc, se.tpc);
                chk("snap_trap_tval", trap_tval, se.tval);
                chk("snap_flags_req_valid_halted_trap",
                    {28'd0, fetch_req, instr_valid, halted, trap}, {28'd0, se.flags});
            end
            prev_req  = fetch_req;
            prev_ack  = fetch_ack;
            prev_addr = fetch_addr;
            if (done || cycle > 3000) begin
                if (!done) begin
                    chk("watchdog_cycles", 32'(cycle), 32'd3000);
                end
                chk("fetch_queue_drained", 32'(fq.size()), 32'd0);
                chk("snap_queue_drained", 32'(sq.size()), 32'd0);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        end
    end

endmodule
